tnaf_digit_fifo: RTL

Buffers the signed τ-adic NAF digit stream from the scalar masking/conversion stage before it reaches the point-multiplication controller. Each digit arrives on a one-cycle strobe as a nonzero flag plus sign, together with a terminal marker. The block packs each digit into a 2-bit code and queues it in a small FIFO. It delivers the digits over a valid/ready handshake and raises back-pressure early enough that the serial converter can pause without losing digits.

---
 rtl/tnaf_digit_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/tnaf_digit_fifo.sv
// tnaf_digit_fifo
// Queues the signed tau-adic NAF digit stream between the scalar
// masking/conversion stage and the point-multiplication controller.
// Each strobed digit is packed as {nz, sign&nz, last} into a DEPTH-entry
// FIFO and delivered over a show-ahead valid/ready handshake.
//
// State table:
//   IDLE  | no frame in progress; next accepted digit starts a frame
//   FILL  | frame in progress, terminal digit not yet received
//   DRAIN | terminal digit queued; input refused until it is popped
//
// Ports:
//   clk, rst (async, active-low), clear (sync flush)
//   in_valid/in_nz/in_sign/in_last : digit strobe from the masking stage
//   in_stall                       : hold request to the upstream converter
//   out_valid/out_ready/out_digit/out_last : consumer handshake
//   digit_count                    : digits accepted in the current frame
//   overflow, proto_err            : sticky error flags
module tnaf_digit_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_nz,
  input  logic             in_sign,
  input  logic             in_last,
  output logic             in_stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_digit,
  output logic             out_last,
  output logic [CNT_W-1:0] digit_count,
  output logic             overflow,
  output logic             proto_err
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  // Upstream enable pipeline is two cycles deep, so stall two entries early.
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - 2);

  state_t      state, state_next;
  logic [2:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] occ, occ_next;
  logic [2:0]  head;
  logic        full, empty;
  logic        pop, push_req, push, drop;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign out_valid = !empty;
  assign out_digit = head[2:1];
  assign out_last  = head[0];

  assign pop      = out_valid && out_ready;
  assign push_req = in_valid && (state != DRAIN);
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign occ      = wr_ptr - rd_ptr;
  assign occ_next = occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (push) state_next = in_last ? DRAIN : FILL;
      FILL:    if (push && in_last) state_next = DRAIN;
      DRAIN:   if (pop && head[0]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 3'b000;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      digit_count <= '0;
      overflow    <= 1'b0;
      proto_err   <= 1'b0;
      in_stall    <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      digit_count <= '0;
      overflow    <= 1'b0;
      proto_err   <= 1'b0;
      in_stall    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {in_nz, in_sign & in_nz, in_last};
        wr_ptr              <= wr_ptr + 1'b1;
        // First digit of a frame restarts the count.
        if (state == IDLE)
          digit_count <= CNT_W'(1);
        else if (!(&digit_count))
          digit_count <= digit_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      if (in_valid && state == DRAIN) proto_err <= 1'b1;
      state    <= state_next;
      // Registered from next-cycle occupancy/state so it is valid the
      // cycle right after the threshold is crossed.
      in_stall <= (occ_next >= STALL_TH) || (state_next == DRAIN);
    end
  end

endmodule
